// File: rtl/sh_pkt_tx.sv
// sh_pkt_tx: frames a packet as preamble marker pulses followed by NRZ data slots, MSB first.
// Define SH_PKT_TX_PARITY_EN to append an even-parity slot after the last data slot.
`timescale 1ns/1ps
module sh_pkt_tx #(
    parameter int SLOT_CYCLES   = 10000,
    parameter int PULSE_WIDTH   = 10,
    parameter int PREAMBLE_SIZE = 8,
    parameter int PACKET_SIZE   = 64,
    parameter int GUARD_CYCLES  = 5000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic [PACKET_SIZE-1:0] pkt_data,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    output logic                   tx_out,
    output logic                   tx_rdy,
    output logic                   busy,
    output logic                   done,
    output logic                   abort
);

    localparam int CNT_W   = $clog2(SLOT_CYCLES);
    localparam int IDX_MAX = (PREAMBLE_SIZE > PACKET_SIZE) ? PREAMBLE_SIZE : PACKET_SIZE;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int GRD_W   = $clog2(GUARD_CYCLES + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_WIDTH);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_SIZE - 1);
    localparam logic [IDX_W-1:0] PKT_LAST  = IDX_W'(PACKET_SIZE - 1);
    localparam logic [GRD_W-1:0] GRD_LAST  = GRD_W'(GUARD_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_GUARD    = 3'd3;
`ifdef SH_PKT_TX_PARITY_EN
    localparam logic [2:0] S_PARITY   = 3'd4;
`endif

    logic [2:0]             state, state_n;
    logic [CNT_W-1:0]       slot_cnt, slot_cnt_n;
    logic [IDX_W-1:0]       slot_idx, slot_idx_n;
    logic [GRD_W-1:0]       guard_cnt, guard_cnt_n;
    logic [PACKET_SIZE-1:0] shreg, shreg_n;
    logic                   done_n, abort_n, tx_out_n;
    logic                   slot_wrap, in_frame;
`ifdef SH_PKT_TX_PARITY_EN
    logic                   parity, parity_n;
`endif

    assign pkt_ready = (state == S_IDLE) && tx_en && rst;
    assign slot_wrap = (slot_cnt == SLOT_LAST);
`ifdef SH_PKT_TX_PARITY_EN
    assign in_frame  = (state == S_PREAMBLE) || (state == S_DATA) || (state == S_PARITY);
`else
    assign in_frame  = (state == S_PREAMBLE) || (state == S_DATA);
`endif

    // Dropping tx_en mid-frame discards the payload and goes straight to the guard gap.
    always_comb begin
        state_n     = state;
        slot_cnt_n  = slot_cnt;
        slot_idx_n  = slot_idx;
        guard_cnt_n = guard_cnt;
        shreg_n     = shreg;
        done_n      = 1'b0;
        abort_n     = 1'b0;
`ifdef SH_PKT_TX_PARITY_EN
        parity_n    = parity;
`endif
        if (in_frame && !tx_en) begin
            state_n     = S_GUARD;
            slot_cnt_n  = '0;
            slot_idx_n  = '0;
            guard_cnt_n = '0;
            shreg_n     = '0;
            abort_n     = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pkt_valid && pkt_ready) begin
                        shreg_n    = pkt_data;
                        slot_cnt_n = '0;
                        slot_idx_n = '0;
                        state_n    = S_PREAMBLE;
`ifdef SH_PKT_TX_PARITY_EN
                        parity_n   = ^pkt_data;
`endif
                    end
                end
                S_PREAMBLE: begin
                    slot_cnt_n = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
                    if (slot_wrap) begin
                        if (slot_idx == PRE_LAST) begin
                            state_n    = S_DATA;
                            slot_idx_n = '0;
                        end else begin
                            slot_idx_n = slot_idx + IDX_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    slot_cnt_n = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
                    if (slot_wrap) begin
                        shreg_n = shreg << 1;
                        if (slot_idx == PKT_LAST) begin
                            slot_idx_n = '0;
`ifdef SH_PKT_TX_PARITY_EN
                            state_n     = S_PARITY;
`else
                            state_n     = S_GUARD;
                            guard_cnt_n = '0;
                            done_n      = 1'b1;
`endif
                        end else begin
                            slot_idx_n = slot_idx + IDX_W'(1);
                        end
                    end
                end
`ifdef SH_PKT_TX_PARITY_EN
                S_PARITY: begin
                    slot_cnt_n = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
                    if (slot_wrap) begin
                        state_n     = S_GUARD;
                        guard_cnt_n = '0;
                        done_n      = 1'b1;
                    end
                end
`endif
                S_GUARD: begin
                    if (guard_cnt == GRD_LAST) begin
                        state_n     = S_IDLE;
                        guard_cnt_n = '0;
                    end else begin
                        guard_cnt_n = guard_cnt + GRD_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Line level is derived from the next state so the registered output lines up with slot_cnt.
    always_comb begin
        tx_out_n = 1'b0;
        case (state_n)
            S_PREAMBLE: tx_out_n = (slot_cnt_n < PULSE_END);
            S_DATA:     tx_out_n = shreg_n[PACKET_SIZE-1];
`ifdef SH_PKT_TX_PARITY_EN
            S_PARITY:   tx_out_n = parity_n;
`endif
            default:    tx_out_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            slot_cnt  <= '0;
            slot_idx  <= '0;
            guard_cnt <= '0;
            shreg     <= '0;
            tx_out    <= 1'b0;
            tx_rdy    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
`ifdef SH_PKT_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            slot_cnt  <= slot_cnt_n;
            slot_idx  <= slot_idx_n;
            guard_cnt <= guard_cnt_n;
            shreg     <= shreg_n;
            tx_out    <= tx_out_n;
`ifdef SH_PKT_TX_PARITY_EN
            tx_rdy    <= (state_n == S_PREAMBLE) || (state_n == S_DATA) || (state_n == S_PARITY);
            parity    <= parity_n;
`else
            tx_rdy    <= (state_n == S_PREAMBLE) || (state_n == S_DATA);
`endif
            busy      <= (state_n != S_IDLE);
            done      <= done_n;
            abort     <= abort_n;
        end
    end

endmodule

// File: tb/tb_sh_pkt_tx.sv
// tb_sh_pkt_tx: directed-vector scoreboard bench for sh_pkt_tx using short simulation slots.
`timescale 1ns/1ps
module tb_sh_pkt_tx;

    localparam int SC  = 20;
    localparam int PW  = 2;
    localparam int PRE = 8;
    localparam int PKT = 64;
    localparam int G   = 10;
`ifdef SH_PKT_TX_PARITY_EN
    localparam int FRAME_LEN = 1460;
`else
    localparam int FRAME_LEN = 1440;
`endif
    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;

    typedef struct {
        logic [63:0] data;
        int          len;
        int          kind;
        bit          b2b;
    } frame_t;

    frame_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_en = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [63:0] pkt_data = '0;
    logic        pkt_ready, tx_out, tx_rdy, busy, done, abort;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cyc = -1000;
    bit mon_active = 1'b0;
    logic rdy_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sh_pkt_tx #(
        .SLOT_CYCLES  (SC),
        .PULSE_WIDTH  (PW),
        .PREAMBLE_SIZE(PRE),
        .PACKET_SIZE  (PKT),
        .GUARD_CYCLES (G)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .pkt_data (pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .tx_out   (tx_out),
        .tx_rdy   (tx_rdy),
        .busy     (busy),
        .done     (done),
        .abort    (abort)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference line level for frame cycle i (cycle 0 = first tx_rdy high cycle).
    function automatic logic expBit(input logic [63:0] d, input int i);
        int s;
        int c;
        s = i / SC;
        c = i % SC;
        if (s < PRE) return (c < PW);
        if (s < PRE + PKT) return d[PKT-1-(s-PRE)];
        return ^d;
    endfunction

    task automatic checkFrame(input frame_t f);
        int errs;
        int gcnt;
        int extra;
        errs = 0;
        gcnt = 0;
        extra = 0;
        for (int i = 0; i < f.len; i++) begin
            if (i > 0) @(negedge clk);
            if (tx_out !== expBit(f.data, i) || tx_rdy !== 1'b1) errs++;
            if ((i % SC == SC - 1) || (i == f.len - 1)) begin
                checkOutput($sformatf("slot%0d_bad_cycles", i / SC), 64'(errs), 64'd0);
                errs = 0;
            end
        end
        @(negedge clk);
        checkOutput("end_tx_rdy", 64'(tx_rdy), 64'd0);
        checkOutput("end_tx_out", 64'(tx_out), 64'd0);
        checkOutput("end_done", 64'(done), 64'(f.kind == K_DONE));
        checkOutput("end_abort", 64'(abort), 64'(f.kind == K_ABORT));
        checkOutput("end_busy", 64'(busy), 64'(f.kind != K_RESET));
        if (done === 1'b1) done_cyc = cyc;
        if (f.kind != K_RESET) begin
            while (busy === 1'b1 && gcnt < G + 20) begin
                gcnt++;
                @(negedge clk);
                if (done === 1'b1 || abort === 1'b1) extra++;
            end
            checkOutput("guard_cycles", 64'(gcnt), 64'(G));
            checkOutput("extra_pulses", 64'(extra), 64'd0);
        end
    endtask

    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (tx_rdy === 1'b1 && rdy_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame_tx_rdy", 64'(tx_rdy), 64'd0);
                end else begin
                    mon_active = 1'b1;
                    f = exp_q.pop_front();
                    if (f.b2b) checkOutput("b2b_accept_after_done", 64'(cyc - done_cyc), 64'(G + 1));
                    checkFrame(f);
                    mon_active = 1'b0;
                end
            end
            rdy_prev = tx_rdy;
        end
    end

    task automatic pushFrame(input logic [63:0] d, input int len, input int kind, input bit b2b);
        frame_t f;
        f.data = d;
        f.len  = len;
        f.kind = kind;
        f.b2b  = b2b;
        exp_q.push_back(f);
    endtask

    task automatic applyStimulus(input logic [63:0] d, input int len, input int kind);
        pushFrame(d, len, kind, 1'b0);
        @(posedge clk); #1;
        pkt_data  = d;
        pkt_valid = 1'b1;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic waitFrameStart(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_rdy !== 1'b1 && n < 20);
        checkOutput(name, 64'(n), 64'd1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || mon_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait_expired", 64'(n >= 3000), 64'd0);
    endtask

    initial begin : stim
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx_out", 64'(tx_out), 64'd0);
        checkOutput("rst_tx_rdy", 64'(tx_rdy), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_abort", 64'(abort), 64'd0);
        checkOutput("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        @(posedge clk); #1;
        rst   = 1'b1;
        tx_en = 1'b1;
        @(negedge clk);
        checkOutput("idle_pkt_ready", 64'(pkt_ready), 64'd1);

        $display("[TB] basic frame");
        applyStimulus(64'hA5A5_0000_FFFF_8001, FRAME_LEN, K_DONE);
        waitFrameStart("basic_rdy_latency");
        waitIdle();
        checkOutput("basic_ready_return", 64'(pkt_ready), 64'd1);

        $display("[TB] back-to-back frames");
        pushFrame(64'h1357_9BDF_2468_ACE0, FRAME_LEN, K_DONE, 1'b0);
        pushFrame(64'hF0F0_3C3C_0FF0_C3A5, FRAME_LEN, K_DONE, 1'b1);
        @(posedge clk); #1;
        pkt_data  = 64'h1357_9BDF_2468_ACE0;
        pkt_valid = 1'b1;
        @(posedge clk); #1;
        pkt_data  = 64'hF0F0_3C3C_0FF0_C3A5;
        waitFrameStart("b2b_first_rdy_latency");
        n = 0;
        while (tx_rdy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_first_rdy_len", 64'(n), 64'(FRAME_LEN));
        n = 0;
        while (tx_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_rdy_gap", 64'(n), 64'(G + 1));
        pkt_valid = 1'b0;
        waitIdle();

        $display("[TB] abort at data slot 10");
        applyStimulus(64'hDEAD_BEEF_0123_4567, 368, K_ABORT);
        waitFrameStart("abort_rdy_latency");
        repeat (367) @(posedge clk);
        #1 tx_en = 1'b0;
        waitIdle();
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_ready_low", 64'(pkt_ready), 64'd0);
        end
        @(posedge clk); #1 tx_en = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready_restored", 64'(pkt_ready), 64'd1);

        $display("[TB] reset mid-preamble");
        applyStimulus(64'h0123_4567_89AB_CDEF, 66, K_RESET);
        waitFrameStart("rstmid_rdy_latency");
        repeat (65) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_idle_ready", 64'(pkt_ready), 64'd1);
        checkOutput("rstmid_busy", 64'(busy), 64'd0);
        waitIdle();

        $display("[TB] constant payloads");
        applyStimulus(64'h0, FRAME_LEN, K_DONE);
        waitFrameStart("zeros_rdy_latency");
        waitIdle();
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, FRAME_LEN, K_DONE);
        waitFrameStart("ones_rdy_latency");
        waitIdle();
`ifdef SH_PKT_TX_PARITY_EN
        applyStimulus(64'h1, FRAME_LEN, K_DONE);
        waitFrameStart("par1_rdy_latency");
        waitIdle();
        applyStimulus(64'h3, FRAME_LEN, K_DONE);
        waitFrameStart("par3_rdy_latency");
        waitIdle();
`endif

        $display("[TB] tx_en low in idle");
        @(posedge clk); #1;
        tx_en     = 1'b0;
        pkt_valid = 1'b1;
        pkt_data  = 64'h8000_0000_0000_0001;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 0) begin
                checkOutput("txen_low_pkt_ready", 64'(pkt_ready), 64'd0);
                checkOutput("txen_low_tx_out", 64'(tx_out), 64'd0);
            end
        end
        checkOutput("txen_low_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        tx_en     = 1'b1;
        repeat (30) @(negedge clk);

        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sh_pkt_tx.md
Name: sh_pkt_tx

Overview:
- Transmit-side counterpart of the sample/hold pulse-sync receiver.
- Accepts a 64-bit packet over a valid/ready handshake and serialises it on tx_out as framed slots: 8 preamble marker pulses, then 64 NRZ data slots, MSB first.
- Raises tx_rdy for the duration of the frame so the far-end sync block can start its 1 ms slot sampler, which samples at mid-slot.
- Sits between the packet formatter and the RF/optical driver; runs on the 10 MHz system clock (one slot = 1 ms = 10000 cycles).

Parameters:
- SLOT_CYCLES, 10000, clock cycles per slot (must be >= 4).
- PULSE_WIDTH, 10, high time in cycles of each preamble marker pulse (1 .. SLOT_CYCLES-1).
- PREAMBLE_SIZE, 8, number of preamble slots.
- PACKET_SIZE, 64, number of data bits/slots.
- GUARD_CYCLES, 5000, idle gap in cycles after each frame before the next packet is accepted (>= 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- tx_en  in  1  transmit mode enable (high = TX direction selected)
- pkt_data  in  PACKET_SIZE  packet payload, bit [PACKET_SIZE-1] sent first
- pkt_valid  in  1  payload valid
- pkt_ready  out  1  block can accept a payload
- tx_out  out  1  serial line to the driver
- tx_rdy  out  1  frame-active flag; its rising edge marks slot 0 of the preamble
- busy  out  1  high from acceptance until the end of GUARD
- done  out  1  one-cycle pulse when a frame completes normally
- abort  out  1  one-cycle pulse when a frame is cut short because tx_en dropped

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; all outputs 0; shift register, slot_cnt and slot_idx cleared. Reset applied mid-frame takes effect on the same edge: tx_out is low on the following cycle.
- States: IDLE, PREAMBLE, DATA, GUARD.
- pkt_ready = (state==IDLE) && tx_en && rst. It is combinational from state and registered flags only.
- Acceptance: the handshake happens on the edge where pkt_valid && pkt_ready.
  - On that edge: latch pkt_data into the shift register; slot_cnt=0; slot_idx=0; state=PREAMBLE.
  - From the next cycle: tx_rdy=1, busy=1.
- slot_cnt counts 0..SLOT_CYCLES-1 and wraps. On wrap, slot_idx increments.
- PREAMBLE:
  - tx_out=1 while slot_cnt<PULSE_WIDTH, else 0.
  - After slot PREAMBLE_SIZE-1 wraps: state=DATA, slot_idx=0.
- DATA:
  - tx_out = shift register MSB, held for the whole slot.
  - The register shifts left (zero fill) on each slot wrap.
  - After slot PACKET_SIZE-1 wraps: state=GUARD, tx_out=0, tx_rdy=0, done=1 for one cycle.
- GUARD: tx_out=0; count GUARD_CYCLES cycles, then state=IDLE and busy=0.
- Outputs tx_out, tx_rdy, busy, done and abort are all registered.
- Frame length: (PREAMBLE_SIZE+PACKET_SIZE)*SLOT_CYCLES cycles from the first tx_rdy=1 cycle to the first tx_rdy=0 cycle.
- Abort: tx_en==0 in PREAMBLE or DATA causes, on that edge:
  - state=GUARD, tx_out=0, tx_rdy=0, abort=1 for one cycle, done stays 0;
  - the payload is discarded.
- tx_en==0 in IDLE: pkt_ready=0; pkt_valid is ignored.
- tx_en==0 in GUARD: the guard still completes.
- pkt_valid while busy: ignored, no back-pressure side effects; the payload is not queued.
- done and abort are mutually exclusive.
- Widths:
  - slot_cnt: $clog2(SLOT_CYCLES) bits.
  - slot_idx: $clog2(max(PREAMBLE_SIZE,PACKET_SIZE)+1) bits.
  - guard counter: $clog2(GUARD_CYCLES+1) bits.
  - All counters are unsigned and compare with == against parameter-1. No counter overflow is possible.

Optional Feature:
- Macro SH_PKT_TX_PARITY_EN.
- When defined:
  - After the last data slot, one extra slot is transmitted carrying the even parity (XOR) of pkt_data, latched at acceptance.
  - Frame length becomes (PREAMBLE_SIZE+PACKET_SIZE+1)*SLOT_CYCLES.
  - done fires after the parity slot.
  - Abort during the parity slot behaves as abort in DATA.
- When undefined: no parity slot, and no parity register is synthesised.

Test Plan:
- Sim parameters: SLOT_CYCLES=20, PULSE_WIDTH=2, GUARD_CYCLES=10.
- Basic frame: tx_en=1, pkt_data=64'hA5A5_0000_FFFF_8001, one-cycle pkt_valid
  - tx_rdy rises 1 cycle after acceptance;
  - 8 pulses each 2 cycles high, spaced 20 cycles apart;
  - then 64 slots of 20 cycles matching the bits MSB first;
  - tx_rdy high exactly 1440 cycles; done pulses once; busy low 10 cycles later; pkt_ready then returns.
- Back-to-back: pkt_valid held high with 2 payloads queued by the bench
  - second acceptance occurs exactly GUARD_CYCLES+1 cycles after done;
  - pkt_valid during busy is ignored.
- Abort: drop tx_en at DATA slot 10, slot_cnt 7
  - the next cycle shows tx_out=0, tx_rdy=0, abort=1, done never pulses;
  - IDLE is reached 10 cycles later; pkt_ready stays 0 until tx_en=1.
- Reset mid-preamble: rst=0 for 1 cycle at slot 3
  - next cycle: all outputs 0, state IDLE;
  - a fresh packet then transmits normally.
- All-zeros/all-ones payloads: data slots are a constant level;
  - with SH_PKT_TX_PARITY_EN, 64'h1 yields a final slot of 1 and 64'h3 a final slot of 0;
  - tx_rdy high is 1460 cycles.
- tx_en low in IDLE with pkt_valid=1 for 100 cycles: pkt_ready=0, tx_out=0, no frame is started.
